// File: rtl/mux_8_32_pkg.sv
// Shared serial-link definitions: byte/word geometry and the MSB-first lane
// order used by both the 8:32 multiplexer and the 32:8 demultiplexer.
package mux_8_32_pkg;

    localparam int LINK_BYTE_W = 8;
    localparam int LINK_LANES  = 4;
    localparam int LINK_WORD_W = LINK_BYTE_W * LINK_LANES;

    // Lane 0 carries the most significant byte of the word. The function
    // returns the LSB position of a lane's slot inside the word.
    function automatic int lane_lsb(input int word_w, input int byte_w, input int lane_idx);
        return word_w - byte_w * (lane_idx + 32'sd1);
    endfunction

endpackage

// File: rtl/mux_8_32.sv
// Byte-to-word deserializer: gathers LANES valid bytes (first byte in the
// most significant slot) and presents the completed word with a one-cycle
// valid_out strobe. Gaps (valid_in low) freeze all state except the strobe.
module mux_8_32
    import mux_8_32_pkg::*;
#(
    parameter int BYTE_W = LINK_BYTE_W,
    parameter int LANES  = LINK_LANES
) (
    input  logic                      clk_4f,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [BYTE_W-1:0]         data_in,
    output logic                      valid_out,
    output logic [BYTE_W*LANES-1:0]   data_out,
    output logic [$clog2(LANES)-1:0]  lane,
    output logic                      partial
);

    localparam int WORD_W = BYTE_W * LANES;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [WORD_W-1:0] acc_q,   acc_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic [LANE_W-1:0] lane_q,  lane_d;
    logic              partial_q, partial_d;
    logic              valid_q,   valid_d;

    // Next-state: place an accepted byte in its slot, advance the lane, and
    // latch the full word (including the byte just arriving) on the last lane.
    always_comb begin
        acc_d     = acc_q;
        data_d    = data_q;
        lane_d    = lane_q;
        partial_d = partial_q;
        valid_d   = 1'b0;
        if (valid_in) begin
            for (int l = 0; l < LANES; l++) begin
                acc_d[lane_lsb(WORD_W, BYTE_W, l) +: BYTE_W] =
                    (lane_q == LANE_W'(l)) ? data_in
                                           : acc_q[lane_lsb(WORD_W, BYTE_W, l) +: BYTE_W];
            end
            if (lane_q == LAST_LANE) begin
                lane_d  = LANE_W'(0);
                data_d  = acc_d;
                valid_d = 1'b1;
            end else begin
                lane_d  = lane_q + LANE_W'(1);
                data_d  = data_q;
                valid_d = 1'b0;
            end
            partial_d = (lane_d != LANE_W'(0));
        end else begin
            acc_d     = acc_q;
            lane_d    = lane_q;
            partial_d = partial_q;
        end
    end

    // State and output registers; reset discards any partially built word.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            data_q    <= '0;
            lane_q    <= '0;
            partial_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            data_q    <= data_d;
            lane_q    <= lane_d;
            partial_q <= partial_d;
            valid_q   <= valid_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign lane      = lane_q;
    assign partial   = partial_q;

endmodule

// File: tb/tb_mux_8_32.sv
// Self-checking bench for mux_8_32: directed scenarios followed by random
// traffic, all checked every cycle against a byte-queue reference model.
module tb_mux_8_32;

    logic        clk_4f;
    logic        reset;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [1:0]  lane;
    logic        partial;

    int n_cmp;
    int n_err;

    // Reference model: bytes of the word in progress, last word, strobe.
    logic [7:0]  m_bytes[$];
    logic [31:0] m_word;
    logic        m_valid;

    mux_8_32 dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .valid_in (valid_in),
        .data_in  (data_in),
        .valid_out(valid_out),
        .data_out (data_out),
        .lane     (lane),
        .partial  (partial)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic model_reset();
        m_bytes.delete();
        m_word  = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        if (r) begin
            model_reset();
        end else begin
            m_valid = 1'b0;
            if (v) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 4) begin
                    m_word  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_valid = 1'b1;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_lane;
        logic       exp_partial;
        exp_lane    = 2'(m_bytes.size());
        exp_partial = (m_bytes.size() != 0);
        n_cmp++;
        assert (valid_out === m_valid) else begin
            n_err++;
            $error("FAIL %s valid_out: observed %b expected %b", tag, valid_out, m_valid);
        end
        n_cmp++;
        assert (data_out === m_word) else begin
            n_err++;
            $error("FAIL %s data_out: observed %h expected %h", tag, data_out, m_word);
        end
        n_cmp++;
        assert (lane === exp_lane) else begin
            n_err++;
            $error("FAIL %s lane: observed %0d expected %0d", tag, lane, exp_lane);
        end
        n_cmp++;
        assert (partial === exp_partial) else begin
            n_err++;
            $error("FAIL %s partial: observed %b expected %b", tag, partial, exp_partial);
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [7:0] d, input logic r);
        @(negedge clk_4f);
        valid_in = v;
        data_in  = d;
        reset    = r;
        @(posedge clk_4f);
        #1;
        model_edge(v, d, r);
        check(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        cycle(tag, 1'b1, d, 1'b0);
    endtask

    task automatic gap(input string tag);
        cycle(tag, 1'b0, 8'($urandom_range(255, 0)), 1'b0);
    endtask

    logic [7:0] seq_a[8];
    logic       rv;
    logic       rr;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        model_reset();

        // Reset held with valid traffic present.
        for (int i = 0; i < 3; i++) cycle("reset_hold", 1'b1, 8'hFF, 1'b1);

        // Back-to-back words.
        seq_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 8; i++) send("b2b", seq_a[i]);
        gap("b2b_tail");
        n_cmp++;
        assert (data_out === 32'h11223344) else begin
            n_err++;
            $error("FAIL b2b_word2: observed %h expected %h", data_out, 32'h11223344);
        end

        // Gaps between bytes.
        send("gaps", 8'h12); gap("gaps");
        send("gaps", 8'h34); gap("gaps"); gap("gaps");
        send("gaps", 8'h56); send("gaps", 8'h78);
        n_cmp++;
        assert (data_out === 32'h12345678) else begin
            n_err++;
            $error("FAIL gaps_word: observed %h expected %h", data_out, 32'h12345678);
        end
        gap("gaps_tail");

        // Asynchronous reset pulse mid-word, away from any clock edge.
        send("midrst", 8'hA1); send("midrst", 8'hA2);
        @(negedge clk_4f);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midrst_async");
        reset = 1'b0;
        send("midrst", 8'h01); send("midrst", 8'h02);
        send("midrst", 8'h03); send("midrst", 8'h04);
        n_cmp++;
        assert (data_out === 32'h01020304) else begin
            n_err++;
            $error("FAIL midrst_word: observed %h expected %h", data_out, 32'h01020304);
        end

        // Reset coincident with the 4th byte.
        send("coinc", 8'h9A); send("coinc", 8'hBC); send("coinc", 8'hDE);
        cycle("coinc_rst", 1'b1, 8'hF0, 1'b1);
        cycle("coinc_after", 1'b0, 8'h00, 1'b0);

        // Hold after a word with random data on idle cycles.
        send("hold", 8'hCA); send("hold", 8'hFE); send("hold", 8'hBA); send("hold", 8'hBE);
        for (int i = 0; i < 10; i++) gap("hold_idle");
        n_cmp++;
        assert (data_out === 32'hCAFEBABE) else begin
            n_err++;
            $error("FAIL hold_word: observed %h expected %h", data_out, 32'hCAFEBABE);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(3, 0) != 0);
            rr = ($urandom_range(49, 0) == 0);
            cycle("random", rv, 8'($urandom_range(255, 0)), rr);
        end
        cycle("final", 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
